// File: rtl/fir_pkg.sv
// Shared types and helpers for the FIR family: default sample width, sample type,
// interpolator FSM states and a coefficient slicing function.
package fir_pkg;
  localparam int DEFAULT_WIDTH = 16;
  localparam int MAX_TAPS      = 64;

  typedef logic [DEFAULT_WIDTH-1:0] sample_t;

  typedef enum logic {IDLE, BUSY} state_t;

  // c[k] from a packed coefficient vector, zero-padded up to MAX_TAPS entries
  function automatic sample_t coeff_at(input logic [MAX_TAPS*DEFAULT_WIDTH-1:0] coeffs,
                                       input int k);
    return coeffs[DEFAULT_WIDTH*k +: DEFAULT_WIDTH];
  endfunction
endpackage

// File: rtl/fir_phase_mac.sv
// Combinational DEPTH-tap dot product; every product truncated to WIDTH bits and the
// sum wraps modulo 2^WIDTH.
module fir_phase_mac #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic [DEPTH*WIDTH-1:0] x_line,
  input  logic [DEPTH*WIDTH-1:0] c_vec,
  output logic [WIDTH-1:0]       y
);
  always_comb begin
    logic [2*WIDTH-1:0] prod;
    prod = '0;
    y    = '0;
    for (int j = 0; j < DEPTH; j++) begin
      prod = x_line[j*WIDTH +: WIDTH] * c_vec[j*WIDTH +: WIDTH];
      y    = y + prod[WIDTH-1:0];
    end
  end
endmodule

// File: rtl/fir_interpolator.sv
// Polyphase upsample-by-L FIR: each accepted sample yields L branch outputs y_0..y_{L-1}.
// First branch registered one cycle after the input transfer; outputs held under out_ready=0.
module fir_interpolator
  import fir_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int TAPS  = 8,
  parameter int L     = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [TAPS*WIDTH-1:0] coeffs,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data
);
  localparam int DEPTH = TAPS / L;
  localparam int PW    = $clog2(L);

  state_t                 state_q, state_d;
  logic [PW-1:0]          phase_q, phase_d, phase_sel;
  logic [DEPTH*WIDTH-1:0] line_q, line_shifted, mac_line, c_vec;
  logic [WIDTH-1:0]       out_data_q, mac_y;
  logic                   out_valid_q;
  logic                   last_phase, in_xfer, out_xfer;
  logic                   shift_en, load_en;

  assign last_phase = (phase_q == PW'(L-1));
  assign in_ready   = (state_q == IDLE) || (state_q == BUSY && last_phase && out_ready);
  assign in_xfer    = in_valid && in_ready;
  assign out_xfer   = out_valid_q && out_ready;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;

  // x[0] lives in the low word so a shift is a left concatenation
  generate
    if (DEPTH > 1) begin : g_shift
      assign line_shifted = {line_q[(DEPTH-1)*WIDTH-1:0], in_data};
    end else begin : g_single
      assign line_shifted = in_data;
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    shift_en = 1'b0;
    load_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_xfer) begin
          shift_en = 1'b1;
          load_en  = 1'b1;
          phase_d  = '0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (out_xfer) begin
          if (!last_phase) begin
            load_en = 1'b1;
            phase_d = phase_q + PW'(1);
          end else if (in_xfer) begin
            shift_en = 1'b1;
            load_en  = 1'b1;
            phase_d  = '0;
          end else begin
            phase_d = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The MAC always evaluates the branch that will be registered next
  assign mac_line  = shift_en ? line_shifted : line_q;
  assign phase_sel = (shift_en || last_phase) ? '0 : phase_q + PW'(1);

  always_comb begin
    c_vec = '0;
    for (int p = 0; p < L; p++) begin
      if (phase_sel == PW'(p)) begin
        for (int j = 0; j < DEPTH; j++) begin
          c_vec[j*WIDTH +: WIDTH] = coeffs[WIDTH*(L*j+p) +: WIDTH];
        end
      end
    end
  end

  fir_phase_mac #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_mac (
    .x_line(mac_line),
    .c_vec (c_vec),
    .y     (mac_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      line_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      out_valid_q <= (state_d == BUSY);
      if (shift_en) line_q <= line_shifted;
      if (load_en) out_data_q <= mac_y;
    end
  end
endmodule
